// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and helpers for the counter and display-side blocks.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  BCD_MAX    = 4'd9;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  // Clamp a nibble to a legal BCD digit; A-F saturate to 9.
  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD decade with parallel load and ripple carry to the next decade.
module bcd_digit_counter
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       cout
);

  assign cout = cin & (q == BCD_MAX);

  // Load wins over the carry-in, so a coincident increment is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= bcd_sat(load_digit);
    end else if (cin) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_step_counter.sv
// 3-digit BCD up-counter stepped by a button edge or an auto-increment prescaler.
module bcd_step_counter
  import bcd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             inc_btn,
  input  logic             auto_en,
  output logic [BCD_W-1:0] bcd_out,
  output logic             wrap,
  output logic             ovf
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $error("bcd_step_counter: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic             btn_q;
  logic             btn_rise;
  logic [CNT_W-1:0] pre_cnt;
  logic             tick;
  logic             inc_req;
  logic [NUM_DIGITS:0] carry;

  assign btn_rise = inc_btn & ~btn_q;
  assign tick     = auto_en & ~load & (pre_cnt == CNT_W'(DIV - 1));
  assign inc_req  = btn_rise | tick;
  assign carry[0] = inc_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= inc_btn;
    end
  end

  // Prescaler restarts whenever auto mode is off or a load occurs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (!auto_en || load || (pre_cnt == CNT_W'(DIV - 1))) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .cin        (carry[i]),
      .q          (bcd_out[4*i +: 4]),
      .cout       (carry[i+1])
    );
  end

  // Carry out of the top digit marks the 999 -> 000 rollover.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= carry[NUM_DIGITS];
      if (carry[NUM_DIGITS]) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_step_counter.sv
// Scoreboard bench for bcd_step_counter: stimulus queues expected state per clock edge, monitor compares.
module tb_bcd_step_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [11:0] load_val;
  logic        inc_btn;
  logic        auto_en;
  logic [11:0] bcd_out;
  logic        wrap;
  logic        ovf;

  typedef struct {
    string       name;
    int          at;
    logic [11:0] bcd;
    logic        wrap;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   pcnt   = 0;
  int   checks = 0;
  int   errors = 0;

  bcd_step_counter #(.CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .inc_btn  (inc_btn),
    .auto_en  (auto_en),
    .bcd_out  (bcd_out),
    .wrap     (wrap),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  // Expected state k rising edges from now, compared at the following falling edge.
  task automatic chk(input int k, input string name, input logic [11:0] b,
                     input logic w, input logic o);
    exp_t e;
    e.name = name; e.at = pcnt + k; e.bcd = b; e.wrap = w; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= pcnt) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.at != pcnt || bcd_out !== e.bcd || wrap !== e.wrap || ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s @edge %0d (due %0d): got bcd=%h wrap=%b ovf=%b, want bcd=%h wrap=%b ovf=%b",
                 e.name, pcnt, e.at, bcd_out, wrap, ovf, e.bcd, e.wrap, e.ovf);
      end
    end
    if (reset_n === 1'b1) begin
      checks++;
      if (bcd_out[3:0] > 4'd9 || bcd_out[7:4] > 4'd9 || bcd_out[11:8] > 4'd9) begin
        errors++;
        $display("FAIL digit_range @edge %0d: got bcd=%h, want every digit 0-9", pcnt, bcd_out);
      end
    end
  end

  initial begin
    reset_n = 1'b0; load = 1'b0; load_val = '0; inc_btn = 1'b0; auto_en = 1'b0;
    step(2);
    chk(1, "reset_state", 12'h000, 1'b0, 1'b0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // 1: asynchronous reset mid-count, then a held button counts once
    load = 1'b1; load_val = 12'h045;
    chk(1, "load_045", 12'h045, 1'b0, 1'b0);
    step(1);
    load = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    chk(0, "async_reset", 12'h000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    inc_btn = 1'b1;
    chk(1, "hold_first", 12'h001, 1'b0, 1'b0);
    chk(20, "hold_20", 12'h001, 1'b0, 1'b0);
    step(20);
    inc_btn = 1'b0;
    step(1);

    // 2: carry across digits and load sanitising
    load = 1'b1; load_val = 12'h099;
    chk(1, "load_099", 12'h099, 1'b0, 1'b0);
    step(1);
    load = 1'b0; inc_btn = 1'b1;
    chk(1, "carry_100", 12'h100, 1'b0, 1'b0);
    step(1);
    inc_btn = 1'b0;
    step(1);
    load = 1'b1; load_val = 12'h3C7;
    chk(1, "sat_3C7", 12'h397, 1'b0, 1'b0);
    step(1);
    load_val = 12'hFFF;
    chk(1, "sat_FFF", 12'h999, 1'b0, 1'b0);
    step(1);
    load = 1'b0;

    // 3: wrap pulse, sticky overflow, cleared by load
    inc_btn = 1'b1;
    chk(1, "wrap_pulse", 12'h000, 1'b1, 1'b1);
    chk(2, "wrap_end", 12'h000, 1'b0, 1'b1);
    step(1);
    inc_btn = 1'b0;
    chk(2, "ovf_sticky", 12'h000, 1'b0, 1'b1);
    step(2);
    load = 1'b1; load_val = 12'h000;
    chk(1, "ovf_clear", 12'h000, 1'b0, 1'b0);
    step(1);
    load = 1'b0;

    // 4: auto mode timing and prescaler restart
    auto_en = 1'b1;
    chk(9,  "auto_pre10", 12'h000, 1'b0, 1'b0);
    chk(10, "auto_10",    12'h001, 1'b0, 1'b0);
    chk(20, "auto_20",    12'h002, 1'b0, 1'b0);
    chk(30, "auto_30",    12'h003, 1'b0, 1'b0);
    chk(35, "auto_35",    12'h003, 1'b0, 1'b0);
    step(35);
    auto_en = 1'b0;
    step(5);
    auto_en = 1'b1;
    chk(5,  "auto_not45", 12'h003, 1'b0, 1'b0);
    chk(9,  "auto_pre50", 12'h003, 1'b0, 1'b0);
    chk(10, "auto_50",    12'h004, 1'b0, 1'b0);
    step(10);

    // 5: button rise coincident with tick
    chk(9, "pre_coinc", 12'h004, 1'b0, 1'b0);
    step(9);
    inc_btn = 1'b1;
    chk(1, "coinc_plus1", 12'h005, 1'b0, 1'b0);
    chk(2, "coinc_after", 12'h005, 1'b0, 1'b0);
    step(2);
    inc_btn = 1'b0;
    step(1);

    // 6: load beats a coincident button rise and restarts the prescaler
    load = 1'b1; load_val = 12'h123; inc_btn = 1'b1;
    chk(1, "load_beats_btn", 12'h123, 1'b0, 1'b0);
    step(1);
    load = 1'b0;
    chk(9,  "restart_pre", 12'h123, 1'b0, 1'b0);
    chk(10, "restart_tick", 12'h124, 1'b0, 1'b0);
    step(10);
    inc_btn = 1'b0; auto_en = 1'b0;
    step(3);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no comparison, want one at edge %0d", e.name, e.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, want normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
